// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
// State encoding is fixed so the FSM can be decoded from a logic analyser.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef logic [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces one active-low push key.
// Emits a single-cycle press pulse on a debounced release-to-press transition.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_press
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            stable   <= 1'b1;
            stable_d <= 1'b1;
            cnt      <= '0;
            o_press  <= 1'b0;
        end else begin
            sync1    <= i_key_n;
            sync2    <= sync1;
            stable_d <= stable;
            o_press  <= stable_d & ~stable;
            // Any cycle agreeing with the accepted level restarts the run length.
            if (sync2 != stable) begin
                if (cnt == CNT_LAST) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/lap/clear stopwatch: key debouncing, tick prescaler, 4-digit BCD
// counter with a lap hold register and a display mux.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV     = 500000,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_key_ss_n,
    input  logic               i_key_lap_n,
    output logic [DIGIT_W-1:0] o_units,
    output logic [DIGIT_W-1:0] o_tens,
    output logic [DIGIT_W-1:0] o_hundreds,
    output logic [DIGIT_W-1:0] o_thousands,
    output logic               o_running,
    output logic               o_lap_held,
    output logic               o_wrap
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic ss_press;
    logic lap_raw_press;
    logic lap_press;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_ss (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_key_n (i_key_ss_n),
        .o_press (ss_press)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_lap (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_key_n (i_key_lap_n),
        .o_press (lap_raw_press)
    );

    // Start/stop takes priority when both keys land in the same cycle.
    assign lap_press = lap_raw_press & ~ss_press;

    state_t             state;
    state_t             state_next;
    logic               capture;
    logic               clear;
    logic               counting;
    logic               tick;
    logic [PW-1:0]      presc;
    digit_t [3:0]       count;
    digit_t [3:0]       count_next;
    digit_t [3:0]       hold;
    logic               carry;

    assign counting = (state == RUN) || (state == LAP);
    assign tick     = counting && (presc == PRESC_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        clear      = 1'b0;
        case (state)
            IDLE: begin
                if (ss_press) state_next = RUN;
            end
            RUN: begin
                if (ss_press) begin
                    state_next = PAUSE;
                end else if (lap_press) begin
                    state_next = LAP;
                    capture    = 1'b1;
                end
            end
            LAP: begin
                if (ss_press)       state_next = PAUSE;
                else if (lap_press) state_next = RUN;
            end
            PAUSE: begin
                if (ss_press) begin
                    state_next = RUN;
                end else if (lap_press) begin
                    state_next = IDLE;
                    clear      = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Decade ripple chain; carry out of the top digit marks the 9999 rollover.
    always_comb begin
        count_next = count;
        carry      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (count[i] == BCD_MAX) begin
                    count_next[i] = '0;
                end else begin
                    count_next[i] = count[i] + 1'b1;
                    carry         = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc      <= '0;
            count      <= '0;
            hold       <= '0;
            o_wrap     <= 1'b0;
            o_running  <= 1'b0;
            o_lap_held <= 1'b0;
        end else begin
            o_wrap     <= 1'b0;
            o_running  <= (state_next == RUN) || (state_next == LAP);
            o_lap_held <= (state_next == LAP);
            if (clear) begin
                presc <= '0;
                count <= '0;
            end else if (tick) begin
                presc  <= '0;
                count  <= count_next;
                o_wrap <= carry;
            end else if (counting) begin
                presc <= presc + 1'b1;
            end
            // Captures the pre-tick value when a lap press coincides with a tick.
            if (capture) hold <= count;
        end
    end

    assign o_units     = o_lap_held ? hold[0] : count[0];
    assign o_tens      = o_lap_held ? hold[1] : count[1];
    assign o_hundreds  = o_lap_held ? hold[2] : count[2];
    assign o_thousands = o_lap_held ? hold[3] : count[3];

endmodule
